// File: rtl/rotator_engine.sv
// rotator_engine: multi-mode rotate/shift engine, one bit position per clock.
// A word and command are taken through a valid/ready handshake, the requested
// rotate/shift is applied serially, and the result is held until consumed.
// Optional feature macro: ROTATOR_CARRY_EN adds out_carry (last bit moved out).
module rotator_engine #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AMT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef ROTATOR_CARRY_EN
  ,
  output logic             out_carry
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Mode 11 is reserved and decodes as rotate.
  typedef enum logic [1:0] {
    MODE_ROT = 2'b00,
    MODE_LSH = 2'b01,
    MODE_ASH = 2'b10,
    MODE_RSV = 2'b11
  } mode_e;

  state_e           state_q;
  mode_e            mode_q;
  logic             dir_q;
  logic [WIDTH-1:0] data_q;
  logic [AMT_W-1:0] cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] step_data_d;
  logic [AMT_W-1:0] amt_eff;

`ifdef ROTATOR_CARRY_EN
  logic             carry_q;
  logic             step_carry_d;

  // Bit leaving the word on one step: MSB for left, LSB for right.
  assign step_carry_d = dir_q ? data_q[0] : data_q[WIDTH-1];
  assign out_carry    = carry_q;
`endif

  // Amounts beyond WIDTH-1 can only occur for non-power-of-two widths.
  if ((WIDTH & (WIDTH - 1)) == 0) begin : g_amt_pow2
    assign amt_eff = in_amt;
  end else begin : g_amt_clamp
    assign amt_eff = (in_amt > AMT_W'(WIDTH - 1)) ? AMT_W'(WIDTH - 1) : in_amt;
  end

  // One-position step of the working word for the latched direction and mode.
  always_comb begin
    step_data_d = data_q;
    if (!dir_q) begin
      if (mode_q == MODE_LSH || mode_q == MODE_ASH) begin
        step_data_d = {data_q[WIDTH-2:0], 1'b0};
      end else begin
        step_data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
      end
    end else begin
      case (mode_q)
        MODE_LSH: step_data_d = {1'b0, data_q[WIDTH-1:1]};
        MODE_ASH: step_data_d = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
        default:  step_data_d = {data_q[0], data_q[WIDTH-1:1]};
      endcase
    end
  end

  // Control FSM with registered handshake outputs and the working datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= MODE_ROT;
      dir_q       <= 1'b0;
      data_q      <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ROTATOR_CARRY_EN
      carry_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            data_q     <= in_data;
            dir_q      <= in_dir;
            mode_q     <= mode_e'(in_mode);
            cnt_q      <= amt_eff;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef ROTATOR_CARRY_EN
            carry_q    <= 1'b0;
`endif
            if (amt_eff == '0) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          data_q <= step_data_d;
          cnt_q  <= cnt_q - AMT_W'(1);
`ifdef ROTATOR_CARRY_EN
          carry_q <= step_carry_d;
`endif
          if (cnt_q == AMT_W'(1)) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_rotator_engine.sv
// Testbench for rotator_engine (WIDTH=8): vector table, scoreboard queue,
// backpressure and mid-operation reset sequences.
module tb_rotator_engine;

  localparam int unsigned W  = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_dir;
  logic [1:0]    in_mode;
  logic [AW-1:0] in_amt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;
`ifdef ROTATOR_CARRY_EN
  logic          out_carry;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rotator_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_dir    (in_dir),
    .in_mode   (in_mode),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef ROTATOR_CARRY_EN
    ,
    .out_carry (out_carry)
`endif
  );

  typedef struct {
    logic [W-1:0]  data;
    logic          dir;
    logic [1:0]    mode;
    logic [AW-1:0] amt;
    logic [W-1:0]  exp_data;
    logic          exp_carry;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic         carry;
    int           amt;
  } exp_t;

  localparam int NV = 13;
  vec_t vecs [NV];
  exp_t sb [$];

  int checks = 0;
  int errors = 0;
  int prev_acc = 0;
  int prev_amt = 0;
  bit prev_fast = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one operation; hold>0 keeps out_ready low for that many cycles in DONE.
  task automatic run_op(input vec_t v, input int hold, input string tag);
    int   n;
    int   lat;
    int   acc;
    exp_t e;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_data   = v.data;
    in_dir    = v.dir;
    in_mode   = v.mode;
    in_amt    = v.amt;
    @(posedge clk);
    e.data  = v.exp_data;
    e.carry = v.exp_carry;
    e.amt   = int'(v.amt);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    acc = cyc;
    if (prev_fast) check({tag, " throughput"}, 32'(acc - prev_acc), 32'(prev_amt + 2));
    check({tag, " busy after accept"}, 32'(busy), 32'd1);
    check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(int'(v.amt) + 1));
    e = sb.pop_front();
    check({tag, " out_data"}, 32'(out_data), 32'(e.data));
`ifdef ROTATOR_CARRY_EN
    check({tag, " out_carry"}, 32'(out_carry), 32'(e.carry));
`endif
    for (int k = 0; k < hold; k++) begin
      in_valid = k[0];
      in_data  = ~v.data;
      in_amt   = 3'd0;
      @(negedge clk);
      check({tag, " held out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " held out_data"}, 32'(out_data), 32'(e.data));
      check({tag, " held in_ready"}, 32'(in_ready), 32'd0);
`ifdef ROTATOR_CARRY_EN
      check({tag, " held out_carry"}, 32'(out_carry), 32'(e.carry));
`endif
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " in_ready after handoff"}, 32'(in_ready), 32'd1);
    check({tag, " out_valid after handoff"}, 32'(out_valid), 32'd0);
    check({tag, " busy after handoff"}, 32'(busy), 32'd0);
    prev_acc  = acc;
    prev_amt  = int'(v.amt);
    prev_fast = (hold == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // data, dir, mode, amt, expected data, expected carry
    vecs[0]  = '{8'h81, 1'b0, 2'd0, 3'd1, 8'h03, 1'b1};
    vecs[1]  = '{8'h01, 1'b1, 2'd0, 3'd3, 8'h20, 1'b0};
    vecs[2]  = '{8'h80, 1'b1, 2'd2, 3'd3, 8'hF0, 1'b0};
    vecs[3]  = '{8'h80, 1'b1, 2'd1, 3'd3, 8'h10, 1'b0};
    vecs[4]  = '{8'hFF, 1'b0, 2'd1, 3'd7, 8'h80, 1'b1};
    vecs[5]  = '{8'h5A, 1'b0, 2'd0, 3'd0, 8'h5A, 1'b0};
    vecs[6]  = '{8'h3C, 1'b1, 2'd3, 3'd4, 8'hC3, 1'b1};
    vecs[7]  = '{8'hC1, 1'b0, 2'd2, 3'd2, 8'h04, 1'b1};
    vecs[8]  = '{8'h7F, 1'b1, 2'd2, 3'd7, 8'h00, 1'b1};
    vecs[9]  = '{8'h80, 1'b1, 2'd2, 3'd7, 8'hFF, 1'b0};
    vecs[10] = '{8'h12, 1'b0, 2'd0, 3'd7, 8'h09, 1'b1};
    vecs[11] = '{8'hA5, 1'b1, 2'd1, 3'd5, 8'h05, 1'b0};
    vecs[12] = '{8'h00, 1'b1, 2'd2, 3'd0, 8'h00, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_dir    = 1'b0;
    in_mode   = 2'd0;
    in_amt    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
`ifdef ROTATOR_CARRY_EN
    check("reset out_carry", 32'(out_carry), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i], 0, $sformatf("vec%0d", i));
    end

    // Backpressure: result held for 5 cycles while in_valid pulses are ignored.
    run_op(vecs[0], 5, "backpressure");
    run_op(vecs[7], 0, "after_backpressure");

    // Reset during BUSY after three steps, with in_valid also asserted.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_dir   = 1'b0;
    in_mode  = 2'd1;
    in_amt   = 3'd6;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midop busy", 32'(busy), 32'd1);
    check("midop out_valid", 32'(out_valid), 32'd0);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h33;
    in_amt   = 3'd0;
    @(negedge clk);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort busy", 32'(busy), 32'd0);
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort out_data", 32'(out_data), 32'd0);
`ifdef ROTATOR_CARRY_EN
    check("abort out_carry", 32'(out_carry), 32'd0);
`endif
    rst       = 1'b0;
    in_valid  = 1'b0;
    prev_fast = 1'b0;
    @(negedge clk);
    check("post-abort out_valid", 32'(out_valid), 32'd0);
    run_op(vecs[6], 0, "after_abort");
    run_op(vecs[10], 0, "after_abort2");

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
